// File: rtl/shift_unit_seq.sv
// Multi-cycle barrel shifter: one log-stage per clock (shift by 2^k when amount bit k is set).
// Supports SLL, SRL, SRA and ROR with a valid/ready handshake on both sides.
module shift_unit_seq #(
  parameter int WIDTH = 32,
  parameter int AMTW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [AMTW-1:0]  in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  localparam int              KL     = AMTW - 1;
  localparam int              ONE    = 1;
  localparam logic [AMTW-1:0] K_LAST = KL[AMTW-1:0];
  localparam logic [AMTW-1:0] K_ONE  = ONE[AMTW-1:0];

  state_t           state_q;
  logic [AMTW-1:0]  k_q;
  logic [AMTW-1:0]  amt_q;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] data_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [WIDTH-1:0] shift_d;
  logic             accept_d;
  int               step_s;

  // Arithmetic shift of the working value keeps the operand's sign bit replicating at the top.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] w, input int s,
                                                  input logic [1:0] m);
    logic [WIDTH-1:0] r;
    case (m)
      2'b00:   r = w << s;
      2'b01:   r = w >> s;
      2'b10:   r = $unsigned($signed(w) >>> s);
      2'b11:   r = (w >> s) | (w << (WIDTH - s));
      default: r = w;
    endcase
    return r;
  endfunction

  assign in_ready  = !flush && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept_d  = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = data_q;
  assign out_zero  = (data_q == '0);

  // Next working value; amt_q is consumed LSB-first so bit 0 always belongs to stage k.
  always_comb begin
    step_s = 32'd1 << k_q;
    if (amt_q[0]) begin
      shift_d = shift_step(work_q, step_s, mode_q);
    end else begin
      shift_d = work_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      amt_q       <= '0;
      mode_q      <= 2'b00;
      work_q      <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            state_q <= SHIFT;
            k_q     <= '0;
            amt_q   <= in_amt;
            mode_q  <= in_mode;
            work_q  <= in_a;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          work_q <= shift_d;
          amt_q  <= {1'b0, amt_q[AMTW-1:1]};
          k_q    <= k_q + K_ONE;
          if (k_q == K_LAST) begin
            state_q     <= DONE;
            data_q      <= shift_d;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          // Result handed off; a simultaneous new request starts immediately.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (accept_d) begin
              state_q <= SHIFT;
              k_q     <= '0;
              amt_q   <= in_amt;
              mode_q  <= in_mode;
              work_q  <= in_a;
              busy_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Scoreboard bench for shift_unit_seq: default 32-bit instance plus an 8-bit instance.
module tb_shift_unit_seq;

  typedef struct {
    logic [31:0] d;
    logic        z;
  } exp_t;

  logic        clk, rst, flush;
  logic        in_valid, in_ready, out_valid, out_ready, out_zero, busy;
  logic [31:0] in_a, out_data;
  logic [4:0]  in_amt;
  logic [1:0]  in_mode;

  logic        flush8, in_valid8, in_ready8, out_valid8, out_ready8, out_zero8, busy8;
  logic [7:0]  in_a8, out_data8;
  logic [2:0]  in_amt8;
  logic [1:0]  in_mode8;

  exp_t q[$];
  exp_t q8[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  shift_unit_seq u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_amt(in_amt), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_zero(out_zero), .busy(busy)
  );

  shift_unit_seq #(.WIDTH(8), .AMTW(3)) u_dut8 (
    .clk(clk), .rst(rst), .flush(flush8), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(in_a8), .in_amt(in_amt8), .in_mode(in_mode8), .out_valid(out_valid8),
    .out_ready(out_ready8), .out_data(out_data8), .out_zero(out_zero8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitors pop the expected response whenever a result handshake completes.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("sb32_unexpected_result", 32'd0, 32'd1);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sb32_data", out_data, e.d);
        check("sb32_zero", {31'd0, out_zero}, {31'd0, e.z});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid8 && out_ready8) begin
      if (q8.size() == 0) begin
        check("sb8_unexpected_result", 32'd0, 32'd1);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("sb8_data", {24'd0, out_data8}, e.d);
        check("sb8_zero", {31'd0, out_zero8}, {31'd0, e.z});
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [4:0] amt, input logic [1:0] mode,
                       input logic [31:0] exp_d, input bit push);
    in_a = a; in_amt = amt; in_mode = mode; in_valid = 1'b1;
    if (push) q.push_back('{d: exp_d, z: (exp_d == 32'd0)});
    #1;
    check("in_ready_at_issue", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int exp_lat);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check(name, lat, exp_lat);
  endtask

  task automatic issue8(input logic [7:0] a, input logic [2:0] amt, input logic [1:0] mode,
                        input logic [7:0] exp_d);
    int lat = 0;
    in_a8 = a; in_amt8 = amt; in_mode8 = mode; in_valid8 = 1'b1;
    q8.push_back('{d: {24'd0, exp_d}, z: (exp_d == 8'd0)});
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    while (!out_valid8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("lat8", lat, 3);
  endtask

  task automatic watch_no_valid(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check(name, seen, 0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = 32'd0; in_amt = 5'd0; in_mode = 2'b00;
    flush8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b1;
    in_a8 = 8'd0; in_amt8 = 3'd0; in_mode8 = 2'b00;
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_zero", {31'd0, out_zero}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;

    issue(32'h8000_0000, 5'd4, 2'b10, 32'hF800_0000, 1'b1); wait_valid("lat_sra", 5);
    issue(32'h8000_0000, 5'd4, 2'b01, 32'h0800_0000, 1'b1); wait_valid("lat_srl", 5);
    issue(32'h1234_5678, 5'd8, 2'b11, 32'h7812_3456, 1'b1); wait_valid("lat_ror", 5);
    issue(32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 1'b1); wait_valid("lat_sll31", 5);
    issue(32'h0000_0001, 5'd1, 2'b01, 32'h0000_0000, 1'b1); wait_valid("lat_srl_zero", 5);
    issue(32'hDEAD_BEEF, 5'd0, 2'b10, 32'hDEAD_BEEF, 1'b1); wait_valid("lat_amt0", 5);
    issue(32'h0000_000F, 5'd4, 2'b11, 32'hF000_0000, 1'b1); wait_valid("lat_ror4", 5);
    issue(32'hA5A5_A5A5, 5'd16, 2'b00, 32'hA5A5_0000, 1'b1); wait_valid("lat_sll16", 5);
    issue(32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000, 1'b1); wait_valid("lat_sra_pos", 5);
    issue(32'hFFFF_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 1'b1); wait_valid("lat_sra_neg", 5);

    // Backpressure for three cycles, then back-to-back acceptance on release.
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(32'h0000_F000, 5'd12, 2'b01, 32'h0000_000F, 1'b1);
    wait_valid("lat_bp", 5);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_valid_held", {31'd0, out_valid}, 32'd1);
      check("bp_data_held", out_data, 32'h0000_000F);
      check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    issue(32'h0000_0003, 5'd1, 2'b00, 32'h0000_0006, 1'b1);
    wait_valid("lat_b2b", 5);
    @(posedge clk); #1;

    // Flush at stage k=2 discards the operation.
    issue(32'h1111_1111, 5'd3, 2'b00, 32'd0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    watch_no_valid("flush_no_valid", 8);

    // Flush in IDLE blocks acceptance.
    flush = 1'b1; in_valid = 1'b1; in_a = 32'h2222_2222; in_amt = 5'd2;
    #1;
    check("flush_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idle_no_accept", {31'd0, busy}, 32'd0);
    watch_no_valid("flush_idle_no_valid", 8);

    // Asynchronous reset at stage k=3.
    issue(32'h3333_3333, 5'd5, 2'b01, 32'd0, 1'b0);
    @(posedge clk); @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_out_data", out_data, 32'd0);
    check("arst_out_zero", {31'd0, out_zero}, 32'd1);
    #1;
    rst = 1'b0;
    issue(32'h0000_00F0, 5'd4, 2'b01, 32'h0000_000F, 1'b1);
    wait_valid("lat_post_rst", 5);
    @(posedge clk); #1;

    issue8(8'h96, 3'd3, 2'b10, 8'hF2);
    @(posedge clk); #1;
    issue8(8'h96, 3'd0, 2'b10, 8'h96);
    @(posedge clk); #1;
    issue8(8'h96, 3'd3, 2'b11, 8'hD2);
    @(posedge clk); #1;
    issue8(8'h96, 3'd7, 2'b00, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;

    check("sb32_drained", q.size(), 32'd0);
    check("sb8_drained", q8.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/shift_unit_seq.md
SHIFT_UNIT_SEQ -- requirements
Module: shift_unit_seq

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, data width; power of two, minimum 4.
REQ-002 SHALL provide parameter AMTW, default 5, shift-amount width; equal to log2(WIDTH).
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  reset; asynchronous and active-high.
REQ-005 SHALL provide port flush  input  1  synchronous abort of any in-flight operation.
REQ-006 SHALL provide port in_valid  input  1  request present.
REQ-007 SHALL provide port in_ready  output  1  unit accepts a request this cycle.
REQ-008 SHALL provide port in_a  input  WIDTH  operand to shift.
REQ-009 SHALL provide port in_amt  input  AMTW  shift amount, unsigned, 0..WIDTH-1.
REQ-010 SHALL provide port in_mode  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-011 SHALL provide port out_valid  output  1  result present.
REQ-012 SHALL provide port out_ready  input  1  consumer takes result.
REQ-013 SHALL provide port out_data  output  WIDTH  shifted result.
REQ-014 SHALL provide port out_zero  output  1  out_data equals zero.
REQ-015 SHALL provide port busy  output  1  high in SHIFT or DONE.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-017 SHALL accept a request on a rising edge where in_valid and in_ready are both high, registering in_a, in_amt, in_mode; stage counter cleared to 0; state goes to SHIFT.
REQ-018 SHALL drive in_ready = (state==IDLE) or (state==DONE and out_ready), with flush low; in_ready low in SHIFT.
REQ-019 SHALL in SHIFT, on each edge with stage counter k, shift the working register by 2^k positions if latched amt bit k is 1, else hold it; then increment k.
REQ-020 SHALL transition SHIFT to DONE on the edge processing k = AMTW-1; out_valid therefore rises exactly AMTW edges after acceptance (5 for default).
REQ-021 SHALL fill vacated bits with 0 for SLL and SRL, with latched operand bit WIDTH-1 for SRA, and with bits rotated out the low end for ROR.
REQ-022 SHALL perform amount 0 with the same fixed latency, returning the operand unchanged.
REQ-023 SHALL hold out_valid, out_data, out_zero stable in DONE until out_ready is high.
REQ-024 SHALL in DONE with out_ready high: go to SHIFT if a new request is accepted that edge (back-to-back), else to IDLE.
REQ-025 SHALL drive out_valid high only in DONE; out_data reflects the working register and is don't-care-stable otherwise (holds last value).
REQ-026 SHALL compute out_zero combinationally as (out_data == 0).
REQ-027 SHALL on flush high return to IDLE on the next edge from any state, discarding the operation and producing no out_valid; flush has priority over acceptance and over out_ready in DONE.
REQ-028 SHALL ignore in_a, in_amt, in_mode changes while not accepting.

Reset
REQ-029 SHALL on rst high, immediately and independent of clk: state IDLE, stage counter 0, working register 0, out_valid 0, busy 0, in_ready 1 (when flush low), out_data 0, out_zero 1.
REQ-030 SHALL, when rst asserts mid-SHIFT or in DONE, discard the operation with no out_valid pulse after rst deasserts.
REQ-031 SHALL accept a new request on the first rising edge after rst deasserts.

Verification
REQ-032 SRA: in_a=0x80000000, amt=4, mode=10 -> out_valid 5 edges after accept, out_data=0xF8000000, out_zero=0; same with mode=01 -> 0x08000000.
REQ-033 ROR/SLL: in_a=0x12345678, amt=8, mode=11 -> 0x78123456; in_a=0x00000001, amt=31, mode=00 -> 0x80000000; in_a=0x00000001, amt=1, mode=01 -> 0x00000000, out_zero=1.
REQ-034 Backpressure/back-to-back: out_ready low 3 cycles in DONE -> out_valid and out_data held, in_ready 0; then out_ready high with in_valid high -> new request accepted same edge, out_valid drops for 5 cycles.
REQ-035 Flush: flush pulsed at stage k=2 -> IDLE next edge, no out_valid; flush with in_valid high in IDLE -> no acceptance.
REQ-036 Reset mid-op: rst asserted asynchronously at stage k=3 -> outputs at reset values before next clk edge; no result after release; request accepted on first post-reset edge.
REQ-037 Parameter sweep: WIDTH=8, AMTW=3, in_a=0x96, amt=3, mode=10 -> 0xF2 after 3 edges; amt=0 -> 0x96.
